oq_port_rate_limiter: RTL

//  Per-port pacing stage directly downstream of one output-queue port (out_data_N/out_ctrl_N/out_wr_N/out_rdy_N).

---
 rtl/oq_port_rate_limiter_if.sv | 14 +
 rtl/oq_port_rate_limiter.sv | 137 +++++++++++++
 2 files changed

// File: rtl/oq_port_rate_limiter_if.sv
// Word-stream link between an output-queue port and its consumer.
// The master drives data/ctrl/wr and the slave answers with rdy.
interface oq_port_rate_limiter_if #(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = DATA_WIDTH / 8
);
    logic [DATA_WIDTH-1:0] data;
    logic [CTRL_WIDTH-1:0] ctrl;
    logic                  wr;
    logic                  rdy;

    modport master (output data, output ctrl, output wr, input rdy);
    modport slave  (input data, input ctrl, input wr, output rdy);
endinterface

// File: rtl/oq_port_rate_limiter.sv
// Per-port pacing stage: buffers output-queue words in a small FIFO and forwards
// whole packets to the MAC TX queue with a programmable idle gap between them.
module oq_port_rate_limiter #(
    parameter int DATA_WIDTH      = 64,
    parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
    parameter int FIFO_DEPTH_BITS = 3,
    parameter int GAP_WIDTH       = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    oq_port_rate_limiter_if.slave  in_bus,
    oq_port_rate_limiter_if.master out_bus,
    input  logic                   enable,
    input  logic [GAP_WIDTH-1:0]   gap_cycles,
    input  logic                   clear_counters,
    output logic [31:0]            pkt_sent_cnt,
    output logic [31:0]            word_sent_cnt,
    output logic                   overflow,
    output logic                   busy
);
    localparam int DEPTH = 1 << FIFO_DEPTH_BITS;
    localparam int WORD_WIDTH = DATA_WIDTH + CTRL_WIDTH;
    localparam logic [FIFO_DEPTH_BITS-1:0] PTR_ONE = 1;
    localparam logic [FIFO_DEPTH_BITS:0] CNT_ONE = 1;
    localparam logic [FIFO_DEPTH_BITS:0] CNT_FULL = DEPTH[FIFO_DEPTH_BITS:0];
    localparam logic [FIFO_DEPTH_BITS:0] CNT_RDY_LIMIT = CNT_FULL - CNT_ONE;
    localparam logic [GAP_WIDTH-1:0] GAP_ONE = 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [WORD_WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH-1:0]           nz_reg;
    logic [FIFO_DEPTH_BITS-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [FIFO_DEPTH_BITS:0]   count_reg, count_next;
    logic [1:0]                 state_reg, state_next;
    logic [GAP_WIDTH-1:0]       gap_reg, gap_next;
    logic [WORD_WIDTH-1:0]      out_word_reg;
    logic                       out_wr_reg, out_eop_reg;

    logic empty, full, pop_ok, pop, push, head_nz, eop_pop;

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_FULL);
    assign pop_ok  = (state_reg == S_HDR) || (state_reg == S_DATA) ||
                     ((state_reg == S_IDLE) && enable);
    assign pop     = out_bus.rdy && !empty && pop_ok;
    // A full FIFO still accepts a write in the same cycle a word leaves it.
    assign push    = in_bus.wr && (!full || pop);
    assign head_nz = nz_reg[rd_ptr_reg];
    assign eop_pop = pop && (state_reg == S_DATA) && head_nz;

    assign in_bus.rdy    = (count_reg < CNT_RDY_LIMIT);
    assign out_bus.data  = out_word_reg[DATA_WIDTH-1:0];
    assign out_bus.ctrl  = out_word_reg[WORD_WIDTH-1:DATA_WIDTH];
    assign out_bus.wr    = out_wr_reg;
    assign busy          = (state_reg != S_IDLE);

    always_comb begin
        count_next = count_reg;
        if (push && !pop)
            count_next = count_reg + CNT_ONE;
        else if (pop && !push)
            count_next = count_reg - CNT_ONE;
    end

    always_comb begin
        state_next = state_reg;
        gap_next   = gap_reg;
        case (state_reg)
            S_IDLE: if (pop) state_next = head_nz ? S_HDR : S_DATA;
            S_HDR:  if (pop && !head_nz) state_next = S_DATA;
            S_DATA: begin
                if (eop_pop) begin
                    gap_next   = gap_cycles;
                    state_next = (gap_cycles == '0) ? S_IDLE : S_GAP;
                end
            end
            default: begin
                // The gap length is latched at EOP, so later gap_cycles writes wait.
                gap_next = gap_reg - GAP_ONE;
                if (gap_reg <= GAP_ONE)
                    state_next = S_IDLE;
            end
        endcase
    end

    // Storage array carries no reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr_reg] <= {in_bus.ctrl, in_bus.data};
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            nz_reg        <= '0;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            state_reg     <= S_IDLE;
            gap_reg       <= '0;
            out_word_reg  <= '0;
            out_wr_reg    <= 1'b0;
            out_eop_reg   <= 1'b0;
            overflow      <= 1'b0;
            pkt_sent_cnt  <= '0;
            word_sent_cnt <= '0;
        end else begin
            if (push) begin
                nz_reg[wr_ptr_reg] <= |in_bus.ctrl;
                wr_ptr_reg         <= wr_ptr_reg + PTR_ONE;
            end
            if (pop) begin
                out_word_reg <= mem[rd_ptr_reg];
                rd_ptr_reg   <= rd_ptr_reg + PTR_ONE;
            end
            out_wr_reg  <= pop;
            out_eop_reg <= eop_pop;
            count_reg   <= count_next;
            state_reg   <= state_next;
            gap_reg     <= gap_next;
            if (in_bus.wr && !push)
                overflow <= 1'b1;
            // A clear coinciding with a send leaves the count at one.
            if (clear_counters)
                word_sent_cnt <= {31'd0, out_wr_reg};
            else
                word_sent_cnt <= word_sent_cnt + {31'd0, out_wr_reg};
            if (clear_counters)
                pkt_sent_cnt <= {31'd0, out_wr_reg && out_eop_reg};
            else
                pkt_sent_cnt <= pkt_sent_cnt + {31'd0, out_wr_reg && out_eop_reg};
        end
    end
endmodule
